// File: rtl/csc_unpack_pkg.sv
// Shared flag indices, phase encoding and lane flag struct for the CSC unpack slice.
package csc_pkg;
   localparam int MFW        = 4;
   localparam int SFW        = 2;
   localparam int MF_VALID   = 0;
   localparam int MF_USER_LO = 1;
   localparam int MF_USER_HI = 2;
   localparam int MF_LAST    = 3;
   localparam int SF_STALL   = 0;
   localparam int SF_AFULL   = 1;
   localparam int NUM_LANES  = 3;

   typedef enum logic [1:0] {PH0 = 2'd0, PH1 = 2'd1, PH2 = 2'd2} phase_t;

   // Bit layout matches the mflags port: {last, user[1:0], valid}.
   typedef struct packed {
      logic       last;
      logic [1:0] user;
      logic       valid;
   } mflags_t;
endpackage

// File: rtl/csc_lane.sv
// One output component lane: a single data+flags register with load and drain.
module csc_lane
   import csc_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] ld_d,
   input  mflags_t      ld_mf,
   input  logic         stall,
   output logic [W-1:0] d,
   output mflags_t      mf,
   output logic         free
);
   // Load wins over drain so a lane emptying this cycle can be refilled with no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         d  <= '0;
         mf <= '0;
      end else if (load) begin
         d  <= ld_d;
         mf <= ld_mf;
      end else if (mf.valid && !stall) begin
         mf.valid <= 1'b0;
      end
   end

   assign free = !mf.valid || !stall;
endmodule

// File: rtl/csc_unpack.sv
// Splits an interleaved c0/c1/c2 stream into three lanes, one triplet at a time.
// Optional malformed-line counter enabled by CSC_UNPACK_ERRCNT_EN.
module csc_unpack
   import csc_pkg::*;
#(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   s_d,
   input  logic [MFW-1:0] s_mflags,
   output logic [SFW-1:0] s_sflags,
   output logic [W-1:0]   x0,
   output logic [W-1:0]   x1,
   output logic [W-1:0]   x2,
   output logic [MFW-1:0] x0_mflags,
   output logic [MFW-1:0] x1_mflags,
   output logic [MFW-1:0] x2_mflags,
   input  logic [SFW-1:0] x0_sflags,
   input  logic [SFW-1:0] x1_sflags,
   input  logic [SFW-1:0] x2_sflags,
   output logic [15:0]    err_cnt
);
   phase_t phase, phase_nx;
   logic [W-1:0] c0, c1;
   logic in_xfer, stall_up, load, err_evt, lanes_free;

   logic    [NUM_LANES-1:0][W-1:0] lane_d, lane_q;
   mflags_t [NUM_LANES-1:0]        lane_mf;
   logic    [NUM_LANES-1:0]        lane_stall, lane_free, lane_vld;
   mflags_t                        ld_mf;

   always_ff @(posedge clk) begin
      if (rst) phase <= PH0;
      else     phase <= phase_nx;
   end

   always_comb begin
      phase_nx = phase;
      if (err_evt) phase_nx = PH0;
      else if (in_xfer) begin
         case (phase)
            PH0:     phase_nx = PH1;
            PH1:     phase_nx = PH2;
            default: phase_nx = PH0;
         endcase
      end
   end

   // Stall only exists on the phase-2 beat, and depends combinationally on lane stalls.
   always_comb begin
      stall_up = (phase == PH2) && !lanes_free;
      in_xfer  = s_mflags[MF_VALID] && !stall_up;
      load     = in_xfer && (phase == PH2);
      err_evt  = in_xfer && s_mflags[MF_LAST] && (phase != PH2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c0 <= '0;
         c1 <= '0;
      end else if (in_xfer) begin
         if (phase == PH0) c0 <= s_d;
         if (phase == PH1) c1 <= s_d;
      end
   end

   assign ld_mf      = '{last: s_mflags[MF_LAST], user: s_mflags[MF_USER_HI:MF_USER_LO], valid: 1'b1};
   assign lane_d     = {s_d, c1, c0};
   assign lane_stall = {x2_sflags[SF_STALL], x1_sflags[SF_STALL], x0_sflags[SF_STALL]};
   assign lanes_free = &lane_free;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      csc_lane #(.W(W)) u_lane (
         .clk   (clk),
         .rst   (rst),
         .load  (load),
         .ld_d  (lane_d[i]),
         .ld_mf (ld_mf),
         .stall (lane_stall[i]),
         .d     (lane_q[i]),
         .mf    (lane_mf[i]),
         .free  (lane_free[i])
      );
      assign lane_vld[i] = lane_mf[i].valid;
   end

   assign x0        = lane_q[0];
   assign x1        = lane_q[1];
   assign x2        = lane_q[2];
   assign x0_mflags = lane_mf[0];
   assign x1_mflags = lane_mf[1];
   assign x2_mflags = lane_mf[2];

   assign s_sflags[SF_STALL] = stall_up;
   assign s_sflags[SF_AFULL] = |lane_vld;

`ifdef CSC_UNPACK_ERRCNT_EN
   logic [15:0] err_q;
   always_ff @(posedge clk) begin
      if (rst)                               err_q <= '0;
      else if (err_evt && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
   end
   assign err_cnt = err_q;
`else
   assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_csc_unpack.sv
// Directed bench for csc_unpack: triplet split, lane stalls, same-cycle reload,
// malformed line, flag propagation and mid-triplet reset.
module tb_csc_unpack;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_d;
   logic [3:0]  s_mflags;
   logic [1:0]  s_sflags;
   logic [31:0] x0, x1, x2;
   logic [3:0]  x0_mflags, x1_mflags, x2_mflags;
   logic [2:0]  x_stall;
   logic [15:0] err_cnt;
   int          n_cmp = 0;
   int          n_err = 0;
   logic        mon_en = 1'b0;
   logic        saw_stall = 1'b0;

`ifdef CSC_UNPACK_ERRCNT_EN
   localparam logic [15:0] ERR_EXP = 16'd1;
`else
   localparam logic [15:0] ERR_EXP = 16'd0;
`endif

   always #5 clk = ~clk;

   csc_unpack #(.W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_d       (s_d),
      .s_mflags  (s_mflags),
      .s_sflags  (s_sflags),
      .x0        (x0),
      .x1        (x1),
      .x2        (x2),
      .x0_mflags (x0_mflags),
      .x1_mflags (x1_mflags),
      .x2_mflags (x2_mflags),
      .x0_sflags ({1'b0, x_stall[0]}),
      .x1_sflags ({1'b0, x_stall[1]}),
      .x2_sflags ({1'b0, x_stall[2]}),
      .err_cnt   (err_cnt)
   );

   always @(posedge clk) if (mon_en && s_sflags[0]) saw_stall <= 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_lanes(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [2:0] vld);
      chk({tag, "_v"}, {29'd0, x2_mflags[0], x1_mflags[0], x0_mflags[0]}, {29'd0, vld});
      if (vld[0]) chk({tag, "_x0"}, x0, a);
      if (vld[1]) chk({tag, "_x1"}, x1, b);
      if (vld[2]) chk({tag, "_x2"}, x2, c);
   endtask

   // Entered and left on a negedge; returns on the negedge after the beat transfers.
   task automatic send(input logic [31:0] d, input logic [1:0] user, input logic last);
      int n = 0;
      s_d      = d;
      s_mflags = {last, user, 1'b1};
      #1;
      while (s_sflags[0] && n < 50) begin
         @(posedge clk); @(negedge clk); #1;
         n++;
      end
      if (n >= 50) chk("send_timeout", {31'd0, s_sflags[0]}, 32'd0);
      @(posedge clk); @(negedge clk);
      s_mflags = '0;
   endtask

   initial begin
      rst = 1'b1; s_d = '0; s_mflags = '0; x_stall = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      chk("rst_x0mf", {28'd0, x0_mflags}, 32'd0);
      chk("rst_x2", x2, 32'd0);
      chk("rst_sflags", {30'd0, s_sflags}, 32'd0);
      chk("rst_err", {16'd0, err_cnt}, 32'd0);

      // Back-to-back, no downstream stall
      mon_en = 1'b1;
      send(32'h11, 2'b00, 1'b0); send(32'h22, 2'b00, 1'b0); send(32'h33, 2'b00, 1'b0);
      chk_lanes("t1a", 32'h11, 32'h22, 32'h33, 3'b111);
      chk("t1a_afull", {31'd0, s_sflags[1]}, 32'd1);
      send(32'h44, 2'b00, 1'b0); send(32'h55, 2'b00, 1'b0); send(32'h66, 2'b00, 1'b0);
      chk_lanes("t1b", 32'h44, 32'h55, 32'h66, 3'b111);
      mon_en = 1'b0;
      chk("t1_nostall", {31'd0, saw_stall}, 32'd0);

      // Lane 1 stalled while lanes 0 and 2 drain
      @(negedge clk);
      chk_lanes("t2_idle", 0, 0, 0, 3'b000);
      x_stall = 3'b010;
      send(32'h11, 2'b00, 1'b0); send(32'h22, 2'b00, 1'b0); send(32'h33, 2'b00, 1'b0);
      chk_lanes("t2a", 32'h11, 32'h22, 32'h33, 3'b111);
      send(32'h44, 2'b00, 1'b0);
      chk_lanes("t2b", 0, 32'h22, 0, 3'b010);
      send(32'h55, 2'b00, 1'b0);
      s_d = 32'h66; s_mflags = 4'b0001; #1;
      chk("t2_stall0", {31'd0, s_sflags[0]}, 32'd1);
      @(posedge clk); @(negedge clk); #1;
      chk("t2_stall1", {31'd0, s_sflags[0]}, 32'd1);
      chk_lanes("t2c", 0, 32'h22, 0, 3'b010);
      @(posedge clk); @(negedge clk);
      x_stall = 3'b000; #1;
      chk("t2_release", {31'd0, s_sflags[0]}, 32'd0);
      @(posedge clk); @(negedge clk); s_mflags = '0;
      chk_lanes("t2d", 32'h44, 32'h55, 32'h66, 3'b111);

      // All lanes drain and reload on the same edge
      x_stall = 3'b111;
      send(32'h77, 2'b00, 1'b0); send(32'h88, 2'b00, 1'b0);
      s_d = 32'h99; s_mflags = 4'b0001; #1;
      chk("t3_stall", {31'd0, s_sflags[0]}, 32'd1);
      chk_lanes("t3a", 32'h44, 32'h55, 32'h66, 3'b111);
      @(posedge clk); @(negedge clk);
      x_stall = 3'b000; #1;
      chk("t3_release", {31'd0, s_sflags[0]}, 32'd0);
      @(posedge clk); @(negedge clk); s_mflags = '0;
      chk_lanes("t3b", 32'h77, 32'h88, 32'h99, 3'b111);

      // Last on phase-1 beat: discard partial triplet
      send(32'h01, 2'b00, 1'b0); send(32'hAA, 2'b00, 1'b1);
      chk_lanes("t4a", 0, 0, 0, 3'b000);
      chk("t4_err", {16'd0, err_cnt}, {16'd0, ERR_EXP});
      send(32'hB1, 2'b00, 1'b0);
      chk_lanes("t4b", 0, 0, 0, 3'b000);
      send(32'hB2, 2'b00, 1'b0);
      chk_lanes("t4c", 0, 0, 0, 3'b000);
      send(32'hB3, 2'b00, 1'b0);
      chk_lanes("t4d", 32'hB1, 32'hB2, 32'hB3, 3'b111);

      // Last + user bits taken from the phase-2 beat
      send(32'hC1, 2'b00, 1'b0); send(32'hC2, 2'b00, 1'b0); send(32'hC3, 2'b10, 1'b1);
      chk_lanes("t5", 32'hC1, 32'hC2, 32'hC3, 3'b111);
      chk("t5_mf0", {28'd0, x0_mflags}, 32'hD);
      chk("t5_mf1", {28'd0, x1_mflags}, 32'hD);
      chk("t5_mf2", {28'd0, x2_mflags}, 32'hD);

      // Reset mid-triplet with stalled, valid lanes
      x_stall = 3'b111;
      send(32'hD1, 2'b00, 1'b0); send(32'hD2, 2'b00, 1'b0);
      chk("t6_pre_afull", {31'd0, s_sflags[1]}, 32'd1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      chk("t6_x0", x0, 32'd0);
      chk("t6_x1", x1, 32'd0);
      chk("t6_x2", x2, 32'd0);
      chk("t6_mf", {20'd0, x2_mflags, x1_mflags, x0_mflags}, 32'd0);
      chk("t6_sflags", {30'd0, s_sflags}, 32'd0);
      chk("t6_err", {16'd0, err_cnt}, 32'd0);
      x_stall = 3'b000;
      send(32'hE1, 2'b00, 1'b0);
      chk_lanes("t6a", 0, 0, 0, 3'b000);
      send(32'hE2, 2'b00, 1'b0); send(32'hE3, 2'b00, 1'b0);
      chk_lanes("t6b", 32'hE1, 32'hE2, 32'hE3, 3'b111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/csc_unpack.md
# csc_unpack

Upstream neighbour of the 3x3 colour-space-conversion stage. Accepts one interleaved component stream (c0, c1, c2, c0, ...) on a single mflags/sflags port and re-emits each complete triplet as three parallel component streams, x0/x1/x2. Each output stream has its own mflags/sflags handshake and feeds one CSC input buffer. Each output lane drains independently. A new triplet launches only when all three lanes can take it.

## Interface
- W, 32, component data width.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_d  in  W  interleaved component data.
- s_mflags  in  4  upstream flags: [0] valid, [2:1] user bits, [3] last (end of line).
- s_sflags  out  2  to upstream: [0] stall, [1] almost-full hint.
- x0, x1, x2  out  W each  component lanes 0/1/2.
- x0_mflags, x1_mflags, x2_mflags  out  4 each  lane flags, same bit meaning as s_mflags.
- x0_sflags, x1_sflags, x2_sflags  in  2 each  per-lane downstream flags: [0] stall, [1] ignored.
- err_cnt  out  16  malformed-line counter (see Configuration).

## Operation
- Input beat transfers when s_mflags[0]=1 and s_sflags[0]=0 in the same cycle.
- Lane i transfers when xi_mflags[0]=1 and xi_sflags[0]=0.
- phase counter 0→1→2→0 advances on each input transfer.
  - Phase 0 and phase 1 beats are captured into hold regs c0/c1.
- Phase-2 beat loads all three lanes in one cycle:
  - x0←c0, x1←c1, x2←s_d.
  - Each lane: mflags[0]←1, mflags[3]←s_mflags[3], mflags[2:1]←s_mflags[2:1] of the phase-2 beat.
- Lane valid clears on its own transfer. Data and flags hold while valid and stalled.
- lanes_free = AND over i of (!xi_mflags[0] | !xi_sflags[0]).
- s_sflags[0] = (phase==2) & !lanes_free. It is combinational from x*_sflags[0]; there is no stall during phases 0 and 1.
- s_sflags[1] = OR of the three lane valids.
- Malformed line: s_mflags[3]=1 on a phase-0 or phase-1 transfer.
  - The partial triplet is discarded and phase returns to 0.
  - No lane is loaded; the error event fires.
- Data passes through unmodified: no arithmetic and no width change.

## Timing
- Reset: phase=0, c0=c1=0, all lane data 0, all xi_mflags=4'b0000, s_sflags=2'b00, err_cnt=0.
- Reset mid-triplet drops the partial triplet and any lane contents without handshake.
- Latency: a phase-2 transfer in cycle t gives lane valids high in cycle t+1.
- Simultaneous drain and reload: a lane transferring in cycle t may be reloaded in t. The new value is visible in t+1, so there is no bubble.
- Throughput: one component per cycle; with no downstream stall, one triplet every 3 cycles.
- An input with valid low has no effect on phase, even while s_sflags[0] is asserted.

## Configuration
- CSC_UNPACK_ERRCNT_EN defined:
  - err_cnt increments on each malformed-line event and saturates at 16'hFFFF.
  - Cleared only by rst.
- CSC_UNPACK_ERRCNT_EN undefined:
  - err_cnt is tied to 16'h0000 and no counter logic is built.
  - Malformed-line discard behaviour is unchanged.

## Structure
- Shared package csc_pkg holds:
  - mflags bit indices MF_VALID=0 and MF_LAST=3, plus MF_USER as [2:1].
  - sflags indices SF_STALL=0 and SF_AFULL=1.
  - Flag widths MFW=4 and SFW=2.
  - Phase encoding PH0, PH1, PH2.
- One sub-module, csc_lane, is instantiated three times. It holds one output register (data + mflags) and has load and drain ports. It reports its free term for the lanes_free AND.

## Test plan
- No downstream stall; input 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 back-to-back:
  - Cycle after beat 3: x0/x1/x2 = 0x11/0x22/0x33, all valid.
  - Cycle after beat 6: 0x44/0x55/0x66.
  - s_sflags[0] never asserts.
- x1_sflags[0] held high for 5 cycles after the first triplet:
  - x0 and x2 drain.
  - The next phase-2 beat sees s_sflags[0]=1 until x1 drains.
  - x1 stays 0x22 throughout.
- Lane drains and reloads in the same cycle: all three lanes show the new triplet the next cycle, with no idle cycle.
- s_mflags[3]=1 on the second beat (0xAA):
  - No lane is loaded; phase returns to 0.
  - err_cnt=1 with the macro defined, 0 without.
  - The following 3 beats form a normal triplet.
- Last on the phase-2 beat, user bits 2'b10: all lanes show mflags=4'b1101.
- Assert rst for one cycle after beat 2 of a triplet:
  - All outputs return to reset values.
  - The next 3 beats produce a complete triplet starting at x0.
